prescaled_counter: RTL and testbench

PRESCALED_COUNTER -- requirements
Module: prescaled_counter

---
 rtl/counter_pkg.sv | 13 +
 rtl/tick_gen.sv | 40 ++++
 rtl/prescaled_counter.sv | 82 ++++++++
 tb/tb_prescaled_counter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the prescaled counter slice.
// Also sizes the prescaler register from the divide ratio.
package counter_pkg;

  localparam int CLK_HZ    = 12000000;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic int pre_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle step enable
// every DIV enabled hw_clk cycles.
import counter_pkg::*;

module tick_gen #(
  parameter int DIV = 6000000
) (
  input  logic hw_clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int PW = pre_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  assign step = en && (pre_q == LAST);

  always_comb begin
    pre_d = pre_q;
    if (clr || step) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge hw_clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/prescaled_counter.sv
// Up/down counter advanced by a clock-enable prescaler,
// with clear, load, wrap/saturate and terminal-count pulse.
import counter_pkg::*;

module prescaled_counter #(
  parameter int WIDTH    = 8,
  parameter int DIV      = 6000000,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             hw_clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic             step;
  logic             at_bound;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             tick_q;
  logic             tick_d;
  logic             tc_q;
  logic             tc_d;

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .hw_clk(hw_clk),
    .rst   (rst),
    .en    (en),
    .clr   (clr),
    .step  (step)
  );

  always_comb begin
    at_bound = dir ? (q_q == ONES) : (q_q == '0);
    stepped  = dir ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
    q_d      = q_q;
    tick_d   = 1'b0;
    tc_d     = 1'b0;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = load_val;
    end else if (step) begin
      tick_d = 1'b1;
      tc_d   = at_bound;
      // saturating mode parks on the bound it just hit
      if (SATURATE == MODE_SAT && at_bound) begin
        q_d = q_q;
      end else begin
        q_d = stepped;
      end
    end
  end

  always_ff @(posedge hw_clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      q_q    <= q_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
    end
  end

  assign q    = q_q;
  assign tick = tick_q;
  assign tc   = tc_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Scoreboard bench: wrap DIV=3, saturate DIV=3 and wrap DIV=1
// counters, each tick checked for edge, q and tc.
`timescale 1ns/1ps

module tb_prescaled_counter;

  typedef struct {
    int       id;
    int       at;
    logic [3:0] q;
    logic     tc;
  } exp_t;

  logic       clk;
  logic [2:0] rst;
  logic [2:0] en;
  logic [2:0] dir;
  logic [2:0] clr;
  logic [2:0] load;
  logic [3:0] lv0, lv1, lv2;
  logic [3:0] q0, q1, q2;
  logic [2:0] tick;
  logic [2:0] tc;

  int   cyc;
  int   base;
  int   total;
  int   bad;
  exp_t sb[$];

  prescaled_counter #(.WIDTH(4), .DIV(3), .SATURATE(0)) dut_w (
    .hw_clk(clk), .rst(rst[0]), .en(en[0]), .dir(dir[0]),
    .clr(clr[0]), .load(load[0]), .load_val(lv0),
    .q(q0), .tick(tick[0]), .tc(tc[0])
  );

  prescaled_counter #(.WIDTH(4), .DIV(3), .SATURATE(1)) dut_s (
    .hw_clk(clk), .rst(rst[1]), .en(en[1]), .dir(dir[1]),
    .clr(clr[1]), .load(load[1]), .load_val(lv1),
    .q(q1), .tick(tick[1]), .tc(tc[1])
  );

  prescaled_counter #(.WIDTH(4), .DIV(1), .SATURATE(0)) dut_1 (
    .hw_clk(clk), .rst(rst[2]), .en(en[2]), .dir(dir[2]),
    .clr(clr[2]), .load(load[2]), .load_val(lv2),
    .q(q2), .tick(tick[2]), .tc(tc[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] qsel(input int i);
    case (i)
      0:       return q0;
      1:       return q1;
      default: return q2;
    endcase
  endfunction

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void mark();
    base = cyc;
  endfunction

  function automatic void tick_at(input int id, input int rel,
                                  input logic [3:0] qv, input logic tcv);
    exp_t e;
    e.id = id;
    e.at = base + rel;
    e.q  = qv;
    e.tc = tcv;
    sb.push_back(e);
  endfunction

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // monitor: every presented tick must match the next expectation
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (tc[i] && !tick[i]) begin
        total++;
        bad++;
        $display("FAIL tc_no_tick dut=%0d actual tc=1 expected tc=0 cyc=%0d", i, cyc);
      end
      if (tick[i]) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL spurious_tick dut=%0d cyc=%0d q=%0d expected no tick",
                   i, cyc, qsel(i));
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.id != i || e.at != cyc || e.q != qsel(i) || e.tc != tc[i]) begin
            bad++;
            $display("FAIL tick dut=%0d actual cyc=%0d q=%0d tc=%0d expected dut=%0d cyc=%0d q=%0d tc=%0d",
                     i, cyc, qsel(i), tc[i], e.id, e.at, e.q, e.tc);
          end
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    base  = 0;
    rst   = 3'b111;
    en    = '0;
    dir   = '0;
    clr   = '0;
    load  = '0;
    lv0   = '0;
    lv1   = '0;
    lv2   = '0;

    #1;
    chk("rst_q0", int'(q0), 0);
    chk("rst_q1", int'(q1), 0);
    chk("rst_q2", int'(q2), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_tc", int'(tc), 0);
    @(negedge clk);
    rst = '0;

    // free-running up count, tick every 3rd cycle
    mark();
    for (int k = 1; k <= 6; k++) tick_at(0, 3 * k, 4'(k), 1'b0);
    en[0]  = 1'b1;
    dir[0] = 1'b1;
    cyc_n(20);
    en[0]  = 1'b0;

    // wrap through all-ones
    clr[0] = 1'b1;
    cyc_n(1);
    chk("clr_q", int'(q0), 0);
    clr[0]  = 1'b0;
    load[0] = 1'b1;
    lv0     = 4'd14;
    cyc_n(1);
    chk("load_q", int'(q0), 14);
    load[0] = 1'b0;
    mark();
    tick_at(0, 3, 4'd15, 1'b0);
    tick_at(0, 6, 4'd0, 1'b1);
    tick_at(0, 9, 4'd1, 1'b0);
    en[0] = 1'b1;
    cyc_n(9);
    en[0] = 1'b0;

    // clr and load together on a step edge
    mark();
    tick_at(0, 6, 4'd1, 1'b0);
    en[0] = 1'b1;
    cyc_n(2);
    clr[0]  = 1'b1;
    load[0] = 1'b1;
    lv0     = 4'd9;
    cyc_n(1);
    chk("clrld_q", int'(q0), 0);
    chk("clrld_tick", int'(tick[0]), 0);
    clr[0]  = 1'b0;
    load[0] = 1'b0;
    cyc_n(3);
    en[0] = 1'b0;

    // enable gating 1,0,0,1,1
    mark();
    tick_at(0, 5, 4'd2, 1'b0);
    en[0] = 1'b1;
    cyc_n(1);
    en[0] = 1'b0;
    cyc_n(2);
    en[0] = 1'b1;
    cyc_n(2);
    en[0] = 1'b0;

    // saturating down from 1, then up at all-ones
    load[1] = 1'b1;
    lv1     = 4'd1;
    cyc_n(1);
    load[1] = 1'b0;
    mark();
    tick_at(1, 3, 4'd0, 1'b0);
    tick_at(1, 6, 4'd0, 1'b1);
    tick_at(1, 9, 4'd0, 1'b1);
    en[1]  = 1'b1;
    dir[1] = 1'b0;
    cyc_n(9);
    en[1]   = 1'b0;
    load[1] = 1'b1;
    lv1     = 4'd15;
    cyc_n(1);
    load[1] = 1'b0;
    mark();
    tick_at(1, 3, 4'd15, 1'b1);
    dir[1] = 1'b1;
    en[1]  = 1'b1;
    cyc_n(3);
    en[1] = 1'b0;

    // async reset mid-prescale with q=7, pre=1
    load[0] = 1'b1;
    lv0     = 4'd7;
    cyc_n(1);
    load[0] = 1'b0;
    en[0]   = 1'b1;
    cyc_n(1);
    en[0] = 1'b0;
    chk("pre_rst_q", int'(q0), 7);
    #2 rst[0] = 1'b1;
    #1;
    chk("async_q", int'(q0), 0);
    chk("async_tick", int'(tick[0]), 0);
    chk("async_tc", int'(tc[0]), 0);
    #1 rst[0] = 1'b0;
    @(negedge clk);
    mark();
    tick_at(0, 3, 4'd1, 1'b0);
    en[0]  = 1'b1;
    dir[0] = 1'b1;
    cyc_n(3);
    en[0] = 1'b0;

    // DIV=1: tick on every enabled cycle, across async reset
    mark();
    tick_at(2, 1, 4'd1, 1'b0);
    tick_at(2, 2, 4'd2, 1'b0);
    en[2]  = 1'b1;
    dir[2] = 1'b1;
    cyc_n(2);
    en[2] = 1'b0;
    chk("div1_q", int'(q2), 2);
    #2 rst[2] = 1'b1;
    #1;
    chk("div1_async_q", int'(q2), 0);
    chk("div1_async_tick", int'(tick[2]), 0);
    #1 rst[2] = 1'b0;
    @(negedge clk);
    mark();
    for (int k = 1; k <= 5; k++) tick_at(2, k, 4'(k), 1'b0);
    tick_at(2, 6, 4'd4, 1'b0);
    tick_at(2, 7, 4'd3, 1'b0);
    en[2] = 1'b1;
    cyc_n(5);
    dir[2] = 1'b0;
    cyc_n(2);
    en[2]   = 1'b0;
    load[2] = 1'b1;
    lv2     = 4'd0;
    cyc_n(1);
    load[2] = 1'b0;
    mark();
    tick_at(2, 1, 4'd15, 1'b1);
    en[2] = 1'b1;
    cyc_n(1);
    en[2] = 1'b0;

    cyc_n(4);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
